// File: rtl/vmips_pkg.sv
// Shared VMIPS constants: format codes, instruction field bit positions and
// the loader FSM state encoding. The decoder uses the same definitions.
package vmips_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_J = 3'd2;
    localparam logic [2:0] FMT_V = 3'd3;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SH_HI    = 10;
    localparam int SH_LO    = 6;
    localparam int FN_HI    = 5;
    localparam int FN_LO    = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int TGT_HI   = 25;
    localparam int TGT_LO   = 0;
    // V format reuses the shamt slot: bit 10 selects, imme_1 sits in [9:0]
    localparam int SIG_BIT  = 10;
    localparam int IMM10_HI = 9;
    localparam int IMM10_LO = 0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/inst_encoder_loader_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; full/empty derive from the
// count so they never reflect a push or pop happening on the current edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // simultaneous push and pop leave occupancy unchanged
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// VMIPS field-level instruction encoder and instruction-memory loader: packs
// decoded field bundles into words, buffers them and writes consecutive words.
module inst_encoder_loader
    import vmips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target,
    input  logic [9:0]        imm10,
    input  logic              sig_i,
    input  logic              im_stall,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  acc_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       enc_word;
    logic              fmt_bad;
    logic [31:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start_go;
    logic              accept;
    logic              pop;

    always_comb begin
        enc_word = NOP_WORD;
        fmt_bad  = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word[OP_HI:OP_LO] = op;
                enc_word[RS_HI:RS_LO] = rs;
                enc_word[RT_HI:RT_LO] = rt;
                enc_word[RD_HI:RD_LO] = rd;
                enc_word[SH_HI:SH_LO] = shamt;
                enc_word[FN_HI:FN_LO] = funct;
            end
            FMT_I: begin
                enc_word[OP_HI:OP_LO]       = op;
                enc_word[RS_HI:RS_LO]       = rs;
                enc_word[RT_HI:RT_LO]       = rt;
                enc_word[IMM16_HI:IMM16_LO] = imm16;
            end
            FMT_J: begin
                enc_word[OP_HI:OP_LO]   = op;
                enc_word[TGT_HI:TGT_LO] = target;
            end
            FMT_V: begin
                enc_word[OP_HI:OP_LO]       = op;
                enc_word[RS_HI:RS_LO]       = rs;
                enc_word[RT_HI:RT_LO]       = rt;
                enc_word[RD_HI:RD_LO]       = rd;
                enc_word[SIG_BIT]           = sig_i;
                enc_word[IMM10_HI:IMM10_LO] = imm10;
            end
            default: begin
                // illegal format still occupies a slot as a nop
                enc_word = NOP_WORD;
                fmt_bad  = 1'b1;
            end
        endcase
    end

    assign start_go = (state == ST_IDLE) && start;
    assign accept   = in_valid && in_ready;
    assign pop      = ((state == ST_LOAD) || (state == ST_DRAIN)) && !fifo_empty && !im_stall;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_ready uses registered occupancy, so a full FIFO popping this edge stays not-ready
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (prog_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = !fifo_full && (acc_cnt < len);
                if (in_valid && !fifo_full && (acc_cnt < len)
                    && (acc_cnt + LEN_W'(1) == len)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_cnt == len) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len     <= '0;
            acc_cnt <= '0;
            err     <= 1'b0;
        end else if (start_go) begin
            len     <= prog_len;
            acc_cnt <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + LEN_W'(1);
            if (fmt_bad) begin
                err <= 1'b1;
            end
        end
    end

    // address and data hold their last written values while no write issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            wr_cnt   <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= pop;
            if (start_go) begin
                wr_ptr <= base_addr;
                wr_cnt <= '0;
            end else if (pop) begin
                im_addr  <= wr_ptr;
                im_wdata <= fifo_head;
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                wr_cnt   <= wr_cnt + LEN_W'(1);
            end
        end
    end

endmodule
